// File: rtl/inst_encoder.sv
// inst_encoder -- packs RV32I instruction fields (opcode, registers, funct,
// immediate) into a 32-bit instruction word for the instruction-memory loader.
// Valid/ready stream in, one registered output stage out. Each word carries
// a byte address that advances by 4 on every consumed word.
//
// Build option: define INST_ENC_CHECK_EN to flag immediates that do not fit
// the selected format on imm_err. Without it, imm_err reports only illegal
// formats and oversized immediates are truncated silently. In both builds the
// word is still emitted with truncated fields.
module inst_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              imm_err
);

  // Format selector codes carried on in_fmt; 6 and 7 are illegal.
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Canonical nop (addi x0, x0, 0) substituted for illegal formats.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  // Immediate shifts reuse the I slot: funct7 on top, 5-bit shamt below it.
  function automatic logic is_shift(input logic [6:0] op, input logic [2:0] f3);
    return (op == OP_IMM) && ((f3 == F3_SLLI) || (f3 == F3_SRXI));
  endfunction

  // Place every field in its RV32I slot; unused immediate bits are dropped.
  function automatic logic [31:0] pack_fields(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = INST_NOP;
    case (fmt)
      FMT_R: w = {f7, rs2, rs1, f3, rd, op};
      FMT_I: begin
        if (is_shift(op, f3)) w = {f7, imm[4:0], rs1, f3, rd, op};
        else                  w = {imm[11:0], rs1, f3, rd, op};
      end
      FMT_S: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U: w = {imm[31:12], rd, op};
      FMT_J: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = INST_NOP;
    endcase
    return w;
  endfunction

  function automatic logic fmt_illegal(input logic [2:0] fmt);
    return fmt > FMT_J;
  endfunction

`ifdef INST_ENC_CHECK_EN
  // A value fits a signed w-bit field when everything from bit w-1 upward
  // is a pure sign extension, i.e. the arithmetic shift leaves 0 or -1.
  function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned w);
    logic signed [31:0] t;
    t = v >>> (w - 1);
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction

  // True when the immediate cannot be represented by the selected format.
  function automatic logic imm_out_of_range(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [31:0] imm
  );
    logic signed [31:0] v;
    logic               bad;
    v   = $signed(imm);
    bad = 1'b0;
    case (fmt)
      FMT_I: begin
        if (is_shift(op, f3)) bad = (v < 32'sd0) || (v > 32'sd31);
        else                  bad = !fits_signed(v, 12);
      end
      FMT_S: bad = !fits_signed(v, 12);
      FMT_B: bad = !fits_signed(v, 13) || imm[0];
      FMT_J: bad = !fits_signed(v, 21) || imm[0];
      FMT_U: bad = (imm[11:0] != 12'd0);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q,  out_inst_d;
  logic              imm_err_q,   imm_err_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;

  logic [31:0] enc_inst;
  logic        enc_err;
  logic        accept;
  logic        drain;

  // Encode the presented bundle combinationally; it is captured only on accept.
  always_comb begin
    enc_inst = pack_fields(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                           in_funct3, in_funct7, in_imm);
`ifdef INST_ENC_CHECK_EN
    enc_err  = fmt_illegal(in_fmt) ||
               imm_out_of_range(in_fmt, in_opcode, in_funct3, in_imm);
`else
    enc_err  = fmt_illegal(in_fmt);
`endif
  end

  // The output stage can take a new word when empty or being drained now.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  // Next-state: reload on accept (covers drain+accept with no bubble),
  // clear valid on a pure drain, otherwise hold the word stable.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    imm_err_d   = imm_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_inst;
      imm_err_d   = enc_err;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Address counter: clear beats the increment of a same-cycle drain.
  always_comb begin
    addr_d = addr_q;
    if (addr_clr)   addr_d = BASE_ADDR;
    else if (drain) addr_d = addr_q + ADDR_W'(4);
  end

  // Output register; reset drops any in-flight word and rewinds the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      imm_err_q   <= 1'b0;
      addr_q      <= BASE_ADDR;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      imm_err_q   <= imm_err_d;
      addr_q      <= addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign imm_err   = imm_err_q;
  assign out_addr  = addr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a 32-bit-address instance with a non-zero
// base and a 4-bit-address instance (base 0) sharing the same stimulus.
module tb_inst_encoder;

`ifdef INST_ENC_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_clr;
  logic        out_ready;

  logic        in_ready, out_valid, imm_err;
  logic [31:0] out_inst, out_addr;

  logic        w4_in_ready, w4_out_valid, w4_imm_err;
  logic [31:0] w4_out_inst;
  logic [3:0]  w4_out_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .addr_clr(addr_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .imm_err(imm_err)
  );

  inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w4_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .addr_clr(addr_clr), .out_valid(w4_out_valid),
    .out_ready(out_ready), .out_inst(w4_out_inst), .out_addr(w4_out_addr),
    .imm_err(w4_imm_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b0;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step(); step();

    // Reset state
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_err", {31'd0, imm_err}, 32'd0);
    chk("rst_addr", out_addr, BASE);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_w4_addr", {28'd0, w4_out_addr}, 32'd0);
    chk("rst_w4_ready_err", {30'd0, w4_in_ready, w4_imm_err}, 32'd2);
    rst = 1'b0;

    // I: addi x1, x0, -1
    out_ready = 1'b1; in_valid = 1'b1;
    set_fields(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    step();
    chk("I_valid", {31'd0, out_valid}, 32'd1);
    chk("I_inst", out_inst, 32'hFFF0_0093);
    chk("I_addr", out_addr, BASE);
    chk("I_err", {31'd0, imm_err}, 32'd0);

    // B: beq x0, x0, -4 (previous word drains on this edge)
    set_fields(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    step();
    chk("B_inst", out_inst, 32'hFE00_0EE3);
    chk("B_addr", out_addr, BASE + 32'd4);
    chk("B_err", {31'd0, imm_err}, 32'd0);

    // J: jal x1, 8
    set_fields(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    step();
    chk("J_inst", out_inst, 32'h0080_00EF);
    chk("J_addr", out_addr, BASE + 32'd8);

    // U: lui x5, 0x12345
    set_fields(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    step();
    chk("U_inst", out_inst, 32'h1234_52B7);
    chk("U_addr", out_addr, BASE + 32'd12);
    chk("U_err", {31'd0, imm_err}, 32'd0);
    chk("w4_addr_C", {28'd0, w4_out_addr}, 32'hC);
    chk("w4_inst", w4_out_inst, 32'h1234_52B7);

    // Idle: last word drains, 4-bit counter wraps C -> 0
    in_valid = 1'b0;
    step();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_addr", out_addr, BASE + 32'd16);
    chk("w4_wrap", {28'd0, w4_out_addr}, 32'h0);
    chk("w4_valid", {31'd0, w4_out_valid}, 32'd0);

    // Backpressure: R sub x1, x2, x3 captured, then held for 3 cycles
    out_ready = 1'b0; in_valid = 1'b1;
    set_fields(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'd0);
    step();
    chk("R_inst", out_inst, 32'h4031_00B3);
    chk("R_addr", out_addr, BASE + 32'd16);
    chk("R_in_ready", {31'd0, in_ready}, 32'd0);
    // S: sw x5, 8(x2) waits while stalled
    set_fields(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_inst", out_inst, 32'h4031_00B3);
      chk("bp_addr", out_addr, BASE + 32'd16);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("S_inst", out_inst, 32'h0051_2423);
    chk("S_addr", out_addr, BASE + 32'd20);

    // Range: I imm=2048 truncates to 0x800
    set_fields(3'd1, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    step();
    chk("Irange_inst", out_inst, 32'h8000_0013);
    chk("Irange_err", {31'd0, imm_err}, {31'd0, CHK});
    chk("Irange_addr", out_addr, BASE + 32'd24);

    // I-shift: srai x1, x1, 5
    set_fields(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'b101, 7'b0100000, 32'd5);
    step();
    chk("srai_inst", out_inst, 32'h4050_D093);
    chk("srai_err", {31'd0, imm_err}, 32'd0);

    // B with odd offset 3
    set_fields(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    step();
    chk("Bodd_inst", out_inst, 32'h0000_0163);
    chk("Bodd_err", {31'd0, imm_err}, {31'd0, CHK});

    // Illegal format -> nop with error
    set_fields(3'd6, 7'b0110011, 5'd7, 5'd7, 5'd7, 3'd7, 7'd0, 32'hDEAD_BEEF);
    step();
    chk("illegal_inst", out_inst, 32'h0000_0013);
    chk("illegal_err", {31'd0, imm_err}, 32'd1);
    chk("illegal_addr", out_addr, BASE + 32'd36);

    // addr_clr during a drain+accept: clear wins
    set_fields(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    addr_clr = 1'b1;
    step();
    addr_clr = 1'b0;
    chk("clr_addr", out_addr, BASE);
    chk("clr_inst", out_inst, 32'hFFF0_0093);
    chk("clr_err", {31'd0, imm_err}, 32'd0);
    chk("clr_w4_addr", {28'd0, w4_out_addr}, 32'h0);
    in_valid = 1'b0;
    step();
    chk("post_clr_addr", out_addr, BASE + 32'd4);

    // Reset asserted mid-transfer: word dropped asynchronously
    out_ready = 1'b0; in_valid = 1'b1;
    set_fields(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    step();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_inst", out_inst, 32'd0);
    chk("async_rst_addr", out_addr, BASE);
    step();
    rst = 1'b0;
    step();
    chk("after_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("after_rst_addr", out_addr, BASE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
